// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter/rotator: moves up to STEP bits per clock under a start/done handshake.
// Optional carry_out port is enabled by defining SHIFTER_CARRY_EN.
module iter_shift_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
`ifdef SHIFTER_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {M_LSL, M_LSR, M_ASR, M_ROR} mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] shv;
  logic [AMT_W-1:0] cnt_q;
  logic [AMT_W-1:0] amt_clamp;
  logic [AMT_W-1:0] step_amt;
  logic             accept;
  logic             last_step;
`ifdef SHIFTER_CARRY_EN
  logic             carry_q;
  logic             cy;
`endif

  assign amt_clamp = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
  assign step_amt  = (cnt_q < AMT_W'(STEP)) ? cnt_q : AMT_W'(STEP);
  assign last_step = (cnt_q == step_amt);

  // One step is a chain of STEP single-bit moves, each enabled only below step_amt.
  always_comb begin
    shv = sreg_q;
`ifdef SHIFTER_CARRY_EN
    cy  = 1'b0;
`endif
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(step_amt)) begin
`ifdef SHIFTER_CARRY_EN
        cy = (mode_q == M_LSL) ? shv[WIDTH-1] : shv[0];
`endif
        case (mode_q)
          M_LSL: shv = {shv[WIDTH-2:0], 1'b0};
          M_LSR: shv = {1'b0, shv[WIDTH-1:1]};
          M_ASR: shv = {shv[WIDTH-1], shv[WIDTH-1:1]};
          M_ROR: shv = {shv[0], shv[WIDTH-1:1]};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        if (start) accept = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (accept) state_d = (amt_clamp == '0) ? DONE : SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= M_LSL;
      data_out <= '0;
`ifdef SHIFTER_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else if (accept) begin
      sreg_q <= data_in;
      cnt_q  <= amt_clamp;
      mode_q <= mode_t'(mode);
      if (amt_clamp == '0) begin
        data_out <= data_in;
`ifdef SHIFTER_CARRY_EN
        carry_q  <= 1'b0;
`endif
      end
    end else if (state_q == SHIFT) begin
      sreg_q <= shv;
      cnt_q  <= cnt_q - step_amt;
      if (last_step) begin
        data_out <= shv;
`ifdef SHIFTER_CARRY_EN
        carry_q  <= cy;
`endif
      end
    end
  end

`ifdef SHIFTER_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule
